// File: rtl/arb_pkg.sv
// Shared parameters and grant-vector helpers for the round-robin request front end.
package arb_pkg;
  localparam int unsigned N_REQ  = 4;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned ID_W   = $clog2(N_REQ);

  // True for an all-zero vector or exactly one bit set.
  function automatic logic onehot_ok(input logic [N_REQ-1:0] vec);
    return (vec & (vec - 1'b1)) == '0;
  endfunction

  function automatic logic [ID_W-1:0] oh2idx(input logic [N_REQ-1:0] vec);
    logic [ID_W-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < N_REQ; i++)
      if (vec[i]) idx = idx | ID_W'(i);
    return idx;
  endfunction
endpackage

// File: rtl/rr_chan_fifo.sv
// Single-channel request FIFO with combinational head; a push into a full FIFO is
// accepted only when the head is popped on the same edge.
module rr_chan_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty
);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count;
  logic              wr_en;
  logic              rd_en;

  assign full  = (count == (PTR_W+1)'(DEPTH));
  assign empty = (count == '0);
  assign rdata = mem[rd_ptr];
  assign rd_en = pop && !empty;
  // When full, the write slot equals the head slot; the head is read before it is overwritten.
  assign wr_en = push && (!full || rd_en);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/rr_req_queue.sv
// Per-channel request queues feeding the round-robin arbiter; pops the granted
// channel and presents it as a registered one-cycle transfer.
module rr_req_queue #(
  parameter int unsigned N_REQ  = arb_pkg::N_REQ,
  parameter int unsigned DATA_W = arb_pkg::DATA_W,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          in_valid,
  input  logic [N_REQ*DATA_W-1:0]   in_data,
  output logic [N_REQ-1:0]          in_ready,
  output logic [N_REQ-1:0]          REQ,
  input  logic [N_REQ-1:0]          GNT,
  output logic                      out_valid,
  output logic [$clog2(N_REQ)-1:0]  out_id,
  output logic [DATA_W-1:0]         out_data,
  output logic                      gnt_err
);
  import arb_pkg::*;

  logic [N_REQ-1:0]         full;
  logic [N_REQ-1:0]         empty;
  logic [N_REQ-1:0]         pop;
  logic [DATA_W-1:0]        head [N_REQ];
  logic                     gnt_hits;
  logic                     pop_ok;
  logic                     bad_gnt;
  logic [$clog2(N_REQ)-1:0] pop_idx;

  for (genvar k = 0; k < N_REQ; k++) begin : g_chan
    rr_chan_fifo #(
      .DATA_W(DATA_W),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk  (clk),
      .rst  (rst),
      .push (in_valid[k]),
      .pop  (pop[k]),
      .wdata(in_data[k*DATA_W +: DATA_W]),
      .rdata(head[k]),
      .full (full[k]),
      .empty(empty[k])
    );
  end

  assign REQ      = ~empty;
  assign in_ready = ~full;

  always_comb begin
    gnt_hits = |(GNT & ~empty);
    pop_ok   = onehot_ok(GNT) && gnt_hits;
    bad_gnt  = !onehot_ok(GNT) || ((GNT != '0) && !gnt_hits);
    pop      = pop_ok ? GNT : '0;
    pop_idx  = oh2idx(GNT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_id    <= '0;
      out_data  <= '0;
      gnt_err   <= 1'b0;
    end else begin
      out_valid <= pop_ok;
      gnt_err   <= bad_gnt;
      if (pop_ok) begin
        out_id   <= pop_idx;
        out_data <= head[pop_idx];
      end
    end
  end
endmodule
